// File: rtl/bus_arbiter.sv
// bus_arbiter: N-master arbiter for the memory bus with wait states, ready stall and completion pulses.
module bus_arbiter #(
   parameter int N_MASTERS   = 2,
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 0,
   parameter int RR_MODE     = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_MASTERS-1:0]          req_rd,
   input  logic [N_MASTERS-1:0]          req_wr,
   input  logic [N_MASTERS*ADDR_W-1:0]   req_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   req_wdata,
   output logic [N_MASTERS-1:0]          gnt,
   output logic [N_MASTERS-1:0]          done,
   output logic [DATA_W-1:0]             rdata,
   output logic                          busy,
   input  logic                          bus_ready,
   input  logic [DATA_W-1:0]             data_in,
   output logic                          rd_en,
   output logic                          wr_en,
   output logic [ADDR_W-1:0]             addr_out,
   output logic [DATA_W-1:0]             data_out
);
   localparam int PW = N_MASTERS > 1 ? $clog2(N_MASTERS) : 1;
   typedef enum logic {IDLE, ACCESS} state_t;
   state_t r_state, w_next;
   logic [N_MASTERS-1:0] r_gnt, r_done, r_sel, w_act, w_win, w_rot;
   logic [2*N_MASTERS-1:0] w_dbl;
   logic [PW-1:0] r_ptr, w_idx;
   logic [3:0] r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic r_rd, r_wr, w_any, w_finish, w_rd;
   int w_base;
   // Rotate the request vector so the search always scans upward from bit 0.
   always_comb begin
      w_act = req_rd | req_wr;
      w_base = RR_MODE != 0 ? int'(r_ptr) + 1 : 0;
      w_dbl = {w_act, w_act};
      w_rot = N_MASTERS'(w_dbl >> w_base);
      w_any = 1'b0;
      w_idx = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (!w_any && w_rot[i]) begin
            w_any = 1'b1;
            w_idx = PW'(w_base + i >= N_MASTERS ? w_base + i - N_MASTERS : w_base + i);
         end
      end
      w_win = w_any ? (N_MASTERS'(1) << w_idx) : '0;
      w_rd = |(req_rd & w_win);
      w_finish = r_cnt == 4'd0 && bus_ready;
   end
   always_comb begin
      w_next = r_state;
      if (r_state == IDLE && w_any) w_next = ACCESS;
      if (r_state == ACCESS && w_finish) w_next = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt <= '0;
         r_done <= '0;
         r_sel <= '0;
         r_ptr <= PW'(N_MASTERS - 1);
         r_cnt <= '0;
         r_rd <= 1'b0;
         r_wr <= 1'b0;
         r_addr <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         r_gnt <= '0;
         r_done <= '0;
         if (r_state == IDLE && w_any) begin
            r_gnt <= w_win;
            r_sel <= w_win;
            r_ptr <= w_idx;
            r_cnt <= 4'(WAIT_CYCLES);
            r_rd <= w_rd;
            r_wr <= !w_rd && |(req_wr & w_win);
            r_addr <= req_addr[w_idx*ADDR_W +: ADDR_W];
            r_wdata <= w_rd ? '0 : req_wdata[w_idx*DATA_W +: DATA_W];
         end else if (r_state == ACCESS) begin
            if (w_finish) begin
               r_done <= r_sel;
               r_rd <= 1'b0;
               r_wr <= 1'b0;
               r_addr <= '0;
               r_wdata <= '0;
               if (r_rd) r_rdata <= data_in;
            end else if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
         end
      end
   end
   assign gnt = r_gnt;
   assign done = r_done;
   assign rdata = r_rdata;
   assign busy = r_state == ACCESS;
   assign rd_en = r_rd;
   assign wr_en = r_wr;
   assign addr_out = r_addr;
   assign data_out = r_wdata;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table on a fixed-priority 2-master arbiter plus round-robin, wait-state and reset sequences.
module tb_bus_arbiter;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [1:0] rd, wr, gnt, done;
   logic [31:0] addr;
   logic [15:0] wdata;
   logic rdy, busy, rd_en, wr_en;
   logic [7:0] din, rdata, dout;
   logic [15:0] aout;
   logic [2:0] rr_rd, rr_wr, rr_gnt, rr_done;
   logic [47:0] rr_addr;
   logic [23:0] rr_wdata;
   logic rr_busy, rr_rd_en, rr_wr_en;
   logic [7:0] rr_rdata, rr_dout;
   logic [15:0] rr_aout;
   bus_arbiter #(.N_MASTERS(2), .ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(0), .RR_MODE(0)) dut (
      .clk(clk), .rst(rst), .req_rd(rd), .req_wr(wr), .req_addr(addr), .req_wdata(wdata),
      .gnt(gnt), .done(done), .rdata(rdata), .busy(busy), .bus_ready(rdy), .data_in(din),
      .rd_en(rd_en), .wr_en(wr_en), .addr_out(aout), .data_out(dout));
   bus_arbiter #(.N_MASTERS(3), .ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(2), .RR_MODE(1)) dut_rr (
      .clk(clk), .rst(rst), .req_rd(rr_rd), .req_wr(rr_wr), .req_addr(rr_addr), .req_wdata(rr_wdata),
      .gnt(rr_gnt), .done(rr_done), .rdata(rr_rdata), .busy(rr_busy), .bus_ready(1'b1), .data_in(8'h5E),
      .rd_en(rr_rd_en), .wr_en(rr_wr_en), .addr_out(rr_aout), .data_out(rr_dout));
   typedef struct {
      logic [1:0] rd, wr;
      logic [15:0] a0, a1;
      logic [7:0] w0, w1;
      logic rdy;
      logic [7:0] din;
      logic [1:0] gnt, done;
      logic rd_en, wr_en;
      logic [15:0] addr;
      logic [7:0] dout;
      logic busy;
      logic [7:0] rdata;
   } vec_t;
   vec_t v[17];
   int n_pass = 0, n_chk = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [63:0] outs();
      return {25'd0, gnt, done, rd_en, wr_en, aout, dout, busy, rdata};
   endfunction
   initial begin
      int n, cyc;
      logic [2:0] got[6];
      rd = 0; wr = 0; addr = 0; wdata = 0; rdy = 1; din = 0;
      rr_rd = 0; rr_wr = 0; rr_addr = {16'h0C00, 16'h0B00, 16'h0A00}; rr_wdata = 0;
      v[0]  = '{2'b11, 2'b00, 16'h1234, 16'h2222, 8'h00, 8'h00, 1, 8'h11, 2'b01, 2'b00, 1, 0, 16'h1234, 8'h00, 1, 8'h00};
      v[1]  = '{2'b10, 2'b00, 16'h1234, 16'h2222, 8'h00, 8'h00, 1, 8'h11, 2'b00, 2'b01, 0, 0, 16'h0000, 8'h00, 0, 8'h11};
      v[2]  = '{2'b10, 2'b00, 16'h1234, 16'h2222, 8'h00, 8'h00, 1, 8'h22, 2'b10, 2'b00, 1, 0, 16'h2222, 8'h00, 1, 8'h11};
      v[3]  = '{2'b00, 2'b00, 16'h1234, 16'h2222, 8'h00, 8'h00, 1, 8'h22, 2'b00, 2'b10, 0, 0, 16'h0000, 8'h00, 0, 8'h22};
      v[4]  = '{2'b00, 2'b00, 16'h1234, 16'h2222, 8'h00, 8'h00, 1, 8'h33, 2'b00, 2'b00, 0, 0, 16'h0000, 8'h00, 0, 8'h22};
      v[5]  = '{2'b10, 2'b10, 16'h1234, 16'h8000, 8'h00, 8'h77, 1, 8'h00, 2'b10, 2'b00, 1, 0, 16'h8000, 8'h00, 1, 8'h22};
      for (int i = 6; i < 10; i++)
         v[i] = '{2'b00, 2'b00, 16'h1234, 16'h8000, 8'h00, 8'h77, 0, 8'h3C, 2'b00, 2'b00, 1, 0, 16'h8000, 8'h00, 1, 8'h22};
      v[10] = '{2'b00, 2'b00, 16'h1234, 16'h8000, 8'h00, 8'h77, 1, 8'h3C, 2'b00, 2'b10, 0, 0, 16'h0000, 8'h00, 0, 8'h3C};
      v[11] = '{2'b00, 2'b01, 16'hFF40, 16'h8000, 8'hA5, 8'h77, 1, 8'h99, 2'b01, 2'b00, 0, 1, 16'hFF40, 8'hA5, 1, 8'h3C};
      v[12] = '{2'b00, 2'b00, 16'hFF40, 16'h8000, 8'hA5, 8'h77, 1, 8'h99, 2'b00, 2'b01, 0, 0, 16'h0000, 8'h00, 0, 8'h3C};
      v[13] = '{2'b00, 2'b11, 16'h0001, 16'h8000, 8'h5A, 8'h66, 1, 8'h99, 2'b01, 2'b00, 0, 1, 16'h0001, 8'h5A, 1, 8'h3C};
      v[14] = '{2'b00, 2'b10, 16'h0001, 16'h8000, 8'h5A, 8'h66, 1, 8'h99, 2'b00, 2'b01, 0, 0, 16'h0000, 8'h00, 0, 8'h3C};
      v[15] = '{2'b00, 2'b10, 16'h0001, 16'h8000, 8'h5A, 8'h66, 1, 8'h99, 2'b10, 2'b00, 0, 1, 16'h8000, 8'h66, 1, 8'h3C};
      v[16] = '{2'b00, 2'b00, 16'h0001, 16'h8000, 8'h5A, 8'h66, 1, 8'h99, 2'b00, 2'b10, 0, 0, 16'h0000, 8'h00, 0, 8'h3C};
      #2;
      chk("reset_outs", outs(), 64'd0);
      chk("reset_rr_outs", {rr_gnt, rr_done, rr_rd_en, rr_wr_en, rr_aout, rr_dout, rr_busy, rr_rdata}, 64'd0);
      step();
      rst = 0;
      for (int i = 0; i < 17; i++) begin
         rd = v[i].rd; wr = v[i].wr; addr = {v[i].a1, v[i].a0}; wdata = {v[i].w1, v[i].w0};
         rdy = v[i].rdy; din = v[i].din;
         step();
         chk($sformatf("vec%0d", i), outs(), {25'd0, v[i].gnt, v[i].done, v[i].rd_en, v[i].wr_en,
             v[i].addr, v[i].dout, v[i].busy, v[i].rdata});
      end
      rd = 0; wr = 0;
      rr_rd = 3'b111;
      n = 0; cyc = 0;
      while (n < 6 && cyc < 60) begin
         step();
         cyc++;
         if (rr_gnt != 0) begin
            got[n] = rr_gnt;
            n++;
         end
      end
      rr_rd = 0;
      chk("rr_grant_count", 64'(n), 64'd6);
      for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), 64'(got[i]), 64'(3'b001 << (i % 3)));
      cyc = 0;
      while (rr_done == 0 && cyc < 10) begin
         step();
         cyc++;
      end
      chk("rr_last_done", 64'(rr_done), 64'b100);
      step();
      rr_wr = 3'b001; rr_addr[15:0] = 16'hFF40; rr_wdata[7:0] = 8'hA5;
      step();
      rr_wr = 0;
      chk("wait_grant", {rr_gnt, rr_wr_en, rr_rd_en, rr_aout, rr_dout, rr_busy}, {3'b001, 1'b1, 1'b0, 16'hFF40, 8'hA5, 1'b1});
      for (int k = 1; k < 3; k++) begin
         step();
         chk($sformatf("wait_hold%0d", k), {rr_done, rr_wr_en, rr_aout, rr_dout}, {3'b000, 1'b1, 16'hFF40, 8'hA5});
      end
      step();
      chk("wait_done", {rr_done, rr_wr_en, rr_aout, rr_dout, rr_busy}, {3'b001, 1'b0, 16'h0, 8'h0, 1'b0});
      rd = 2'b01; addr = {16'h0, 16'h4000}; rdy = 0;
      step();
      rd = 0;
      chk("rst_pre_grant", {gnt, busy, rd_en, rdata}, {2'b01, 1'b1, 1'b1, 8'h3C});
      #3 rst = 1;
      #1 chk("rst_async", {gnt, busy, rd_en, wr_en, rdata}, 64'd0);
      rdy = 1;
      n = 0;
      for (int k = 0; k < 2; k++) begin
         step();
         if (done != 0) n++;
      end
      rst = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (done != 0 || busy) n++;
      end
      chk("rst_no_done", 64'(n), 64'd0);
      rd = 2'b01; addr = {16'h0, 16'h4000}; din = 8'h4D;
      step();
      rd = 0;
      chk("post_rst_grant", {gnt, rd_en, aout}, {2'b01, 1'b1, 16'h4000});
      step();
      chk("post_rst_done", {done, rdata, busy}, {2'b01, 8'h4D, 1'b0});
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Parametrised multi-master front-end for the system memory bus; the successor to the single-master rd_en/wr_en/addr_out/data_out interface.
- Arbitrates N requestors (CPU, OAM/HDMA DMA, debug port) onto one bus.
- Inserts programmable wait states and honours an external ready stall.
- Returns registered read data and a per-master completion pulse.

Parameters:
N_MASTERS, 2, number of requestor channels (>=1)
ADDR_W, 16, address width
DATA_W, 8, data width
WAIT_CYCLES, 0, fixed wait states added to every access (0..15)
RR_MODE, 0, arbitration policy: 0 = fixed priority (index 0 highest), 1 = round-robin

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
req_rd  input  N_MASTERS  per-master read request
req_wr  input  N_MASTERS  per-master write request
req_addr  input  N_MASTERS*ADDR_W  per-master address, master i at [i*ADDR_W +: ADDR_W]
req_wdata  input  N_MASTERS*DATA_W  per-master write data, same packing
gnt  output  N_MASTERS  one-cycle pulse: request latched
done  output  N_MASTERS  one-cycle pulse: access complete
rdata  output  DATA_W  read data of last completed read, held until next read completes
busy  output  1  high while not IDLE
bus_ready  input  1  external ready; access cannot finish while low
data_in  input  DATA_W  bus read data
rd_en  output  1  bus read strobe
wr_en  output  1  bus write strobe
addr_out  output  ADDR_W  bus address
data_out  output  DATA_W  bus write data

Behaviour:
- Reset (async): state=IDLE. All outputs 0, including gnt, done, rdata, busy and all bus outputs. RR pointer = N_MASTERS-1, so master 0 wins first.
- Reset mid-access aborts immediately: no done, no rdata update.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Active requests are sampled at the clock edge; master m is active when req_rd[m] | req_wr[m].
  - If any master is active, the winner m is chosen at that edge and latched: op, addr, wdata.
  - Next cycle: gnt[m]=1, state=ACCESS, busy=1, bus outputs driven from registers.
- ACCESS:
  - rd_en/wr_en/addr_out/data_out are held stable throughout.
  - Wait counter loads WAIT_CYCLES on entry and decrements each cycle.
  - Access completes on the first cycle where counter==0 and bus_ready==1.
  - On the completion edge: if read, rdata <= data_in; state -> IDLE.
  - The following cycle: done[m]=1 and all bus outputs return to 0.
- Minimum access: WAIT_CYCLES+1 ACCESS cycles; each bus_ready-low cycle at counter==0 extends it by one.
- Back-to-back throughput: one transfer every WAIT_CYCLES+2 cycles. IDLE re-samples requests in the same cycle that done pulses.
- Fixed priority: the lowest active index wins.
- Round-robin: search starts at ptr+1 modulo N_MASTERS; ptr <= winner on grant.
- Simultaneous req_rd and req_wr from one master: treated as a read; the write is dropped.
- Requesters hold requests until gnt and may drop them afterwards, because the arbiter has latched them. A request still high after done is a new request.
- Request deasserted before sampling: ignored, no gnt.
- data_out = 0 during reads; addr_out/data_out = 0 when idle.
- gnt and done are one-hot or zero. At most one gnt bit and one done bit per cycle.

Test Plan:
- Fixed priority, N=2, W=0: both masters request reads in cycle 0 -> gnt=01 in cycle 1, rd_en=1 with addr0 in cycle 1, done=01 in cycle 2. Master 1 then gets gnt=10 in cycle 3 and done=10 in cycle 4.
- Round-robin, N=3, all three hold read requests continuously -> grant order 0,1,2,0,1,2. No master is starved; each gets exactly one grant per 3 transfers.
- WAIT_CYCLES=2: master 0 writes 0xA5 to 0xFF40 -> wr_en/addr_out=0xFF40/data_out=0xA5 stable for exactly 3 cycles, then done pulse, then bus outputs return to 0.
- Read with W=0, bus_ready held low for 4 cycles, data_in=0x3C -> ACCESS lasts 5 cycles. rdata=0x3C and done are seen in the same cycle, the one after ready rises.
- rst asserted mid-ACCESS (asynchronously, between edges) -> rd_en/wr_en/busy/gnt drop to 0 immediately, no done ever pulses, rdata=0. After release, a master-0 request is granted normally.
- Master 1 asserts req_rd and req_wr together, addr=0x8000 -> rd_en=1, wr_en=0, data_out=0. The read completes with done=10.
